// File: rtl/imp_ln_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imp_ln_pkg
// Purpose  : Shared widths, FSM state encoding, result record and the 4-bit
//            square lookup used by the layer-norm statistics controller.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package imp_ln_pkg;

  localparam int DATA_W          = 8;   // element / mean width (signed)
  localparam int EX2_W           = 16;  // E[x^2] / variance width (unsigned)
  localparam int SQ_W            = 15;  // |mean|^2 width, |mean| <= 128
  localparam int N_DEFAULT       = 8;   // elements per frame
  localparam int TIMEOUT_DEFAULT = 32;  // max cycles spent waiting for units

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRIME = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_CALC  = 3'd4;
  localparam logic [STATE_W-1:0] ST_OUT   = 3'd5;

  // Registered result presented while the controller sits in OUT.
  typedef struct packed {
    logic signed [DATA_W-1:0] mean;
    logic [EX2_W-1:0]         variance;
    logic                     err;
  } stat_t;

  // Square of a 4-bit nibble, small enough to be a LUT.
  function automatic logic [7:0] sq4_lut(input logic [3:0] v);
    logic [7:0] r;
    case (v)
      4'd0:    r = 8'd0;
      4'd1:    r = 8'd1;
      4'd2:    r = 8'd4;
      4'd3:    r = 8'd9;
      4'd4:    r = 8'd16;
      4'd5:    r = 8'd25;
      4'd6:    r = 8'd36;
      4'd7:    r = 8'd49;
      4'd8:    r = 8'd64;
      4'd9:    r = 8'd81;
      4'd10:   r = 8'd100;
      4'd11:   r = 8'd121;
      4'd12:   r = 8'd144;
      4'd13:   r = 8'd169;
      4'd14:   r = 8'd196;
      default: r = 8'd225;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imp_ln_stat_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imp_ln_stat_ctrl_if
// Purpose  : Bundles the element input stream, the strobe/result lines of the
//            mean and E[x^2] units and the statistics output handshake.
// Modports : master - the controller (drives o_* signals)
//            slave  - the environment (drives i_* signals)
// Revision : 1.0 - initial release
// ============================================================================
interface imp_ln_stat_ctrl_if;
  import imp_ln_pkg::*;

  logic                     i_x_valid;
  logic signed [DATA_W-1:0] i_x;
  logic                     o_x_ready;
  logic                     o_unit_valid;
  logic signed [DATA_W-1:0] o_unit_x;
  logic                     i_ex_done;
  logic signed [DATA_W-1:0] i_ex;
  logic                     i_ex2_done;
  logic [EX2_W-1:0]         i_ex2;
  logic                     o_stat_valid;
  logic                     i_stat_ready;
  logic signed [DATA_W-1:0] o_mean;
  logic [EX2_W-1:0]         o_var;
  logic                     o_err;
  logic                     o_busy;

  modport master (
    input  i_x_valid, i_x, i_ex_done, i_ex, i_ex2_done, i_ex2, i_stat_ready,
    output o_x_ready, o_unit_valid, o_unit_x, o_stat_valid, o_mean, o_var,
           o_err, o_busy
  );

  modport slave (
    output i_x_valid, i_x, i_ex_done, i_ex, i_ex2_done, i_ex2, i_stat_ready,
    input  o_x_ready, o_unit_valid, o_unit_x, o_stat_valid, o_mean, o_var,
           o_err, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/imp_ln_stat_ctrl_sq8.sv
`default_nettype none
// ============================================================================
// Module   : imp_sq8
// Purpose  : Combinational square of an 8-bit magnitude (0..128) split into
//            nibbles: H^2<<8 + (H*L)<<5 + L^2, where the cross term 2*H*L<<4
//            is folded into a single shift of 5.
// Ports    : a  - unsigned magnitude, at most 128
//            sq - a*a, 15 bits
// Revision : 1.0 - initial release
// ============================================================================
module imp_sq8
  import imp_ln_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  output logic [SQ_W-1:0]   sq
);
  logic [3:0]      hi;
  logic [3:0]      lo;
  logic [7:0]      hl;
  logic [SQ_W-1:0] t_hh;
  logic [SQ_W-1:0] t_hl;
  logic [SQ_W-1:0] t_ll;

  assign hi = a[7:4];
  assign lo = a[3:0];
  assign hl = {4'b0000, hi} * {4'b0000, lo};

  // Terms are kept at the result width; with a <= 128 nothing is lost.
  assign t_hh = {7'd0, sq4_lut(hi)} << 8;
  assign t_hl = {7'd0, hl} << 5;
  assign t_ll = {7'd0, sq4_lut(lo)};

  assign sq = t_hh + t_hl + t_ll;
endmodule
`default_nettype wire

// File: rtl/imp_ln_stat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imp_ln_stat_ctrl
// Purpose  : Frame controller for layer-norm statistics. Primes the mean and
//            E[x^2] units with a dummy beat, streams N elements to them, waits
//            (bounded) for both results, computes var = E[x^2] - mean^2 and
//            presents mean/var with a valid/ready handshake.
// Ports    : i_clk        - clock, rising edge
//            i_rstn       - asynchronous active-low reset
//            bus (master) - element stream, unit strobes/results, result
//                           handshake, busy flag
// Revision : 1.0 - initial release
// ============================================================================
module imp_ln_stat_ctrl
  import imp_ln_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  imp_ln_stat_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(N);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [STATE_W-1:0]       state;
  logic [STATE_W-1:0]       state_nxt;
  logic [CNT_W-1:0]         beat_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     ex_flag;
  logic                     ex2_flag;
  logic signed [DATA_W-1:0] ex_q;
  logic [EX2_W-1:0]         ex2_q;
  stat_t                    res_q;

  logic                     beat_acc;
  logic                     last_beat;
  logic                     both_done;
  logic                     tmo_hit;
  logic [DATA_W-1:0]        mean_abs;
  logic [SQ_W-1:0]          mean_sq;
  logic signed [EX2_W:0]    var_diff;
  logic [EX2_W-1:0]         var_clamped;

  assign beat_acc  = (state == ST_LOAD) && bus.i_x_valid;
  assign last_beat = beat_acc && (beat_cnt == CNT_W'(N - 1));
  // A pulse arriving this cycle counts as set, so same-cycle arrival of the
  // second result moves on without an extra cycle.
  assign both_done = (ex_flag || bus.i_ex_done) && (ex2_flag || bus.i_ex2_done);
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.i_x_valid) state_nxt = ST_PRIME;
      ST_PRIME: state_nxt = ST_LOAD;
      ST_LOAD:  if (last_beat) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (both_done)    state_nxt = ST_CALC;
        else if (tmo_hit) state_nxt = ST_OUT;
      end
      ST_CALC:  state_nxt = ST_OUT;
      ST_OUT:   if (bus.i_stat_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, beat counter and wait-timeout counter
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // Wraps back to zero on the last beat of the frame.
      if (beat_acc) beat_cnt <= beat_cnt + CNT_W'(1);
      if (last_beat)              tmo_cnt <= '0;
      else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Unit result capture; pulses outside WAIT are deliberately dropped
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ex_flag  <= 1'b0;
      ex2_flag <= 1'b0;
      ex_q     <= '0;
      ex2_q    <= '0;
    end else if (state == ST_WAIT) begin
      if (bus.i_ex_done) begin
        ex_flag <= 1'b1;
        ex_q    <= bus.i_ex;
      end
      if (bus.i_ex2_done) begin
        ex2_flag <= 1'b1;
        ex2_q    <= bus.i_ex2;
      end
    end else if ((state == ST_OUT) && bus.i_stat_ready) begin
      ex_flag  <= 1'b0;
      ex2_flag <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Variance: E[x^2] - mean^2 in 17-bit signed
  // --------------------------------------------------------------------------
  assign mean_abs = ex_q[DATA_W-1] ? (~ex_q + DATA_W'(1)) : ex_q;

  imp_sq8 u_sq8 (
    .a  (mean_abs),
    .sq (mean_sq)
  );

  assign var_diff = $signed({1'b0, ex2_q}) - $signed({2'b00, mean_sq});
  // The minuend is at most 16'hFFFF and the subtrahend is non-negative, so a
  // non-negative difference always fits in 16 bits; saturation then reduces
  // to taking the low bits, and only the negative clamp needs logic.
  assign var_clamped = var_diff[EX2_W] ? '0 : var_diff[EX2_W-1:0];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      res_q <= '0;
    end else if (state == ST_CALC) begin
      res_q.mean     <= ex_q;
      res_q.variance <= var_clamped;
      res_q.err      <= 1'b0;
    end else if ((state == ST_WAIT) && !both_done && tmo_hit) begin
      res_q.mean     <= '0;
      res_q.variance <= '0;
      res_q.err      <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.o_x_ready    = (state == ST_LOAD);
  // PRIME issues a zero-valued beat that starts both units.
  assign bus.o_unit_valid = (state == ST_PRIME) || beat_acc;
  assign bus.o_unit_x     = (state == ST_LOAD) ? bus.i_x : '0;
  assign bus.o_stat_valid = (state == ST_OUT);
  assign bus.o_mean       = res_q.mean;
  assign bus.o_var        = res_q.variance;
  assign bus.o_err        = res_q.err;
  assign bus.o_busy       = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_imp_ln_stat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imp_ln_stat_ctrl
// Purpose  : Self-checking bench for imp_ln_stat_ctrl: table of frames with
//            hand-computed results plus reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imp_ln_stat_ctrl;
  localparam int TB_N  = 8;
  localparam int TB_TO = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  imp_ln_stat_ctrl_if bus ();

  imp_ln_stat_ctrl #(.N(TB_N), .TIMEOUT(TB_TO)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int strobes;
  int usum;
  int usq;

  // One frame: elements, beat gap, how the unit results arrive, expectations.
  // ex_at / ex2_at / bogus_at: cycle (1 = first WAIT cycle) of a done pulse,
  // 0 = never. bogus_at pulses i_ex_done with value 50 to test overwrite.
  typedef struct {
    logic [TB_N-1:0][7:0] xs;
    int                   gap;
    bit                   force_u;
    logic [7:0]           f_ex;
    logic [15:0]          f_ex2;
    int                   ex_at;
    int                   ex2_at;
    int                   bogus_at;
    bit                   early;
    int                   hold;
    int                   exp_mean;
    int                   exp_var;
    int                   exp_err;
    int                   exp_lat;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(input logic [63:0] xs, input int gap,
                              input bit force_u, input logic [7:0] f_ex,
                              input logic [15:0] f_ex2, input int ex_at,
                              input int ex2_at, input int bogus_at,
                              input bit early, input int hold,
                              input int exp_mean, input int exp_var,
                              input int exp_err, input int exp_lat);
    vec_t v;
    v.xs = xs; v.gap = gap; v.force_u = force_u; v.f_ex = f_ex;
    v.f_ex2 = f_ex2; v.ex_at = ex_at; v.ex2_at = ex2_at;
    v.bogus_at = bogus_at; v.early = early; v.hold = hold;
    v.exp_mean = exp_mean; v.exp_var = exp_var; v.exp_err = exp_err;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Advance one cycle; the unit model observes strobes at the falling edge.
  task automatic tick();
    int x;
    @(negedge clk);
    if (bus.o_unit_valid === 1'b1) begin
      x = int'($signed(bus.o_unit_x));
      strobes++;
      usum += x;
      usq  += x * x;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int k;
    int guard;
    int lat;
    bit acc;
    logic [7:0]  ex_val;
    logic [15:0] ex2_val;
    strobes = 0; usum = 0; usq = 0;
    bus.i_x = v.xs[0];
    bus.i_x_valid = 1'b1;
    if (v.early) begin
      bus.i_ex2_done = 1'b1;
      bus.i_ex2      = 16'd0;
    end
    k = 0; guard = 0;
    while (k < TB_N && guard < 200) begin
      acc = bus.o_x_ready && bus.i_x_valid;
      tick();
      guard++;
      if (acc) begin
        k++;
        if (k < TB_N) begin
          if (v.gap > 0) begin
            bus.i_x_valid = 1'b0;
            repeat (v.gap) tick();
            bus.i_x_valid = 1'b1;
          end
          bus.i_x = v.xs[k];
        end else begin
          bus.i_x_valid = 1'b0;
        end
      end
    end
    bus.i_x_valid  = 1'b0;
    bus.i_ex2_done = 1'b0;
    chk($sformatf("v%0d_beats", id), k, TB_N);

    // Unit model: mean and E[x^2] over the frame (the dummy beat adds 0).
    ex_val  = v.force_u ? v.f_ex  : 8'(usum >>> 3);
    ex2_val = v.force_u ? v.f_ex2 : 16'(usq >>> 3);

    lat = 1;
    while (lat < 100) begin
      bus.i_ex_done  = (lat == v.ex_at) || (lat == v.bogus_at);
      bus.i_ex       = (lat == v.bogus_at) ? 8'd50 : ex_val;
      bus.i_ex2_done = (lat == v.ex2_at);
      bus.i_ex2      = ex2_val;
      tick();
      lat++;
      if (bus.o_stat_valid === 1'b1) break;
    end
    bus.i_ex_done  = 1'b0;
    bus.i_ex2_done = 1'b0;

    chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d_mean", id), $signed(bus.o_mean), v.exp_mean);
    chk($sformatf("v%0d_var", id), bus.o_var, v.exp_var);
    chk($sformatf("v%0d_err", id), bus.o_err, v.exp_err);
    chk($sformatf("v%0d_ready_in_out", id), bus.o_x_ready, 0);

    // Consumer stalls while a new frame is offered.
    for (int h = 0; h < v.hold; h++) begin
      bus.i_x_valid = 1'b1;
      bus.i_x       = 8'h11;
      tick();
      chk($sformatf("v%0d_hold%0d_valid", id, h), bus.o_stat_valid, 1);
      chk($sformatf("v%0d_hold%0d_ready", id, h), bus.o_x_ready, 0);
      chk($sformatf("v%0d_hold%0d_var", id, h), bus.o_var, v.exp_var);
      chk($sformatf("v%0d_hold%0d_mean", id, h), $signed(bus.o_mean), v.exp_mean);
    end

    bus.i_x_valid    = 1'b0;
    bus.i_stat_ready = 1'b1;
    tick();
    bus.i_stat_ready = 1'b0;
    chk($sformatf("v%0d_valid_after_hs", id), bus.o_stat_valid, 0);
    chk($sformatf("v%0d_busy_after_hs", id), bus.o_busy, 0);
    chk($sformatf("v%0d_strobes", id), strobes, TB_N + 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x_ready"},    bus.o_x_ready,    0);
    chk({tag, "_unit_valid"}, bus.o_unit_valid, 0);
    chk({tag, "_unit_x"},     bus.o_unit_x,     0);
    chk({tag, "_stat_valid"}, bus.o_stat_valid, 0);
    chk({tag, "_mean"},       bus.o_mean,       0);
    chk({tag, "_var"},        bus.o_var,        0);
    chk({tag, "_err"},        bus.o_err,        0);
    chk({tag, "_busy"},       bus.o_busy,       0);
  endtask

  initial begin
    int k;
    int guard;
    bit acc;
    rstn             = 1'b0;
    bus.i_x_valid    = 1'b1;
    bus.i_x          = 8'sd3;
    bus.i_ex_done    = 1'b0;
    bus.i_ex         = '0;
    bus.i_ex2_done   = 1'b0;
    bus.i_ex2        = '0;
    bus.i_stat_ready = 1'b0;
    strobes = 0; usum = 0; usq = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    bus.i_x_valid = 1'b0;
    rstn = 1'b1;
    tick();

    //           elements                                      gap frc f_ex   f_ex2   ex ex2 bog erl hold mean var  err lat
    vt[0]  = mk({8{8'h03}},                                     0, 0, 8'd0,  16'd0,  2, 2, 0, 0, 0,  3,   0,     0, 4);
    vt[1]  = mk({4{8'hFC, 8'h04}},                              1, 0, 8'd0,  16'd0,  2, 2, 0, 0, 0,  0,   16,    0, 4);
    vt[2]  = mk({8{8'h03}},                                     0, 1, 8'd3,  16'd5,  2, 2, 0, 0, 0,  3,   0,     0, 4);
    vt[3]  = mk({8{8'h03}},                                     0, 1, 8'd3,  16'd5,  2, 7, 0, 0, 0,  3,   0,     0, 9);
    vt[4]  = mk({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 0, 8'd0, 16'd0, 2, 2, 0, 0, 10, 4,   9,     0, 4);
    vt[5]  = mk({8{8'hFB}},                                     0, 0, 8'd0,  16'd0,  2, 2, 0, 0, 0,  -5,  0,     0, 4);
    vt[6]  = mk({8{8'h03}},                                     0, 1, 8'h80, 16'd20000, 2, 2, 0, 0, 0, -128, 3616, 0, 4);
    vt[7]  = mk({8{8'h03}},                                     0, 1, 8'h7F, 16'hFFFF, 2, 2, 0, 0, 0, 127, 49406, 0, 4);
    vt[8]  = mk({8{8'h03}},                                     0, 1, 8'h9C, 16'd10100, 6, 2, 0, 0, 0, -100, 100, 0, 8);
    // Ex2 never reported in WAIT (only an early pulse during LOAD): WAIT
    // occupies cycles 1..TB_TO, so valid appears in cycle TB_TO+1.
    vt[9]  = mk({8{8'h01}},                                     0, 0, 8'd0,  16'd0,  2, 0, 0, 1, 0,  0,   0,     1, TB_TO + 1);
    vt[10] = mk({8{8'h03}},                                     0, 1, 8'd10, 16'd150, 4, 5, 2, 0, 0, 10,  50,    0, 7);

    for (int i = 0; i < 11; i++) run_frame(vt[i], i);

    // Reset in the middle of LOAD after four accepted beats.
    bus.i_x       = 8'sd3;
    bus.i_x_valid = 1'b1;
    k = 0; guard = 0;
    while (k < 4 && guard < 50) begin
      acc = bus.o_x_ready && bus.i_x_valid;
      tick();
      guard++;
      if (acc) k++;
    end
    chk("midload_beats", k, 4);
    chk("midload_busy", bus.o_busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midload_rst");
    tick();
    bus.i_x_valid = 1'b0;
    rstn = 1'b1;
    tick();
    run_frame(vt[5], 11);
    run_frame(vt[4], 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
